// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: PWM generator, filtered hall decode with illegal-state
// fault latch, and per-leg dead-time FSMs driving the six inverter switch enables.
module bldc_commutator #(
  parameter int unsigned PWM_W = 8,
  parameter int unsigned DEAD  = 4,
  parameter int unsigned FILT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_en,
  input  logic [PWM_W-1:0] pwm_in,
  input  logic             dir,
  input  logic             H1,
  input  logic             H2,
  input  logic             H3,
  input  logic             clear_fault,
  output logic             pwm_out,
  output logic             AP,
  output logic             AN,
  output logic             BP,
  output logic             BN,
  output logic             CP,
  output logic             CN,
  output logic [2:0]       hall_state,
  output logic             hall_valid,
  output logic             fault
);

  localparam int unsigned DTW = $clog2(DEAD + 1);
  localparam int unsigned FCW = $clog2(FILT + 1);

  typedef enum logic [1:0] {LEG_OFF, LEG_HIGH, LEG_LOW} leg_e;

  function automatic logic legal3(input logic [2:0] v);
    return (v != 3'b000) && (v != 3'b111);
  endfunction

  logic [PWM_W-1:0] cnt_q, duty_q;
  logic             pwm_q;
  logic [2:0]       sync1_q, hs_q, cand_q, hall_q;
  logic [FCW-1:0]   run_q, run_d;
  logic             accept, legal_acc, illegal_acc;
  logic             fault_q, fault_d, valid_q, valid_d;
  logic [2:0]       tab_hi, tab_lo, hi_m, lo_m;
  logic             drive_ok;
  leg_e             req     [3];
  leg_e             state_q [3];
  leg_e             state_d [3];
  logic [2:0][DTW-1:0] dt_q, dt_d;

  // Duty is only sampled at the end of a period so a period is never split.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '1) duty_q <= pwm_in;
      pwm_q <= pwm_en & (cnt_q < duty_q);
    end
  end

  // run_d is the length of the current run of identical synchronised samples.
  always_comb begin
    run_d = FCW'(1);
    if (hs_q == cand_q) begin
      run_d = (run_q == FCW'(FILT)) ? run_q : run_q + 1'b1;
    end
  end

  assign accept      = (hs_q != hall_q) && (run_d == FCW'(FILT));
  assign legal_acc   = accept & legal3(hs_q);
  assign illegal_acc = accept & ~legal3(hs_q);

  always_comb begin
    fault_d = fault_q;
    valid_d = valid_q;
    if (illegal_acc) begin
      fault_d = 1'b1;
      valid_d = 1'b0;
    end else if (clear_fault) begin
      fault_d = 1'b0;
      valid_d = 1'b0;
    end else if (legal_acc) begin
      valid_d = ~fault_q;
    end else if (!fault_q && legal3(hall_q)) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      hs_q    <= '0;
      cand_q  <= '0;
      run_q   <= '0;
      hall_q  <= '0;
      fault_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= {H1, H2, H3};
      hs_q    <= sync1_q;
      cand_q  <= hs_q;
      run_q   <= run_d;
      if (accept) hall_q <= hs_q;
      fault_q <= fault_d;
      valid_q <= valid_d;
    end
  end

  // Leg masks are {C,B,A}.
  always_comb begin
    tab_hi = '0;
    tab_lo = '0;
    case (hall_q)
      3'b101:  begin tab_hi = 3'b001; tab_lo = 3'b010; end
      3'b100:  begin tab_hi = 3'b001; tab_lo = 3'b100; end
      3'b110:  begin tab_hi = 3'b010; tab_lo = 3'b100; end
      3'b010:  begin tab_hi = 3'b010; tab_lo = 3'b001; end
      3'b011:  begin tab_hi = 3'b100; tab_lo = 3'b001; end
      3'b001:  begin tab_hi = 3'b100; tab_lo = 3'b010; end
      default: begin tab_hi = '0;     tab_lo = '0;     end
    endcase
    hi_m = dir ? tab_lo : tab_hi;
    lo_m = dir ? tab_hi : tab_lo;
  end

  assign drive_ok = pwm_en & ~fault_q & valid_q;

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      req[i] = LEG_OFF;
      if (drive_ok) begin
        if (hi_m[i] && pwm_q) req[i] = LEG_HIGH;
        else if (lo_m[i])     req[i] = LEG_LOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) state_q[i] <= LEG_OFF;
      dt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) state_q[i] <= state_d[i];
      dt_q <= dt_d;
    end
  end

  // Every leg passes through OFF for DEAD cycles between any two on-states.
  always_comb begin
    dt_d = dt_q;
    for (int unsigned i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      if (state_q[i] != LEG_OFF) begin
        if (req[i] != state_q[i]) begin
          state_d[i] = LEG_OFF;
          dt_d[i]    = DTW'(DEAD);
        end
      end else if (dt_q[i] != '0) begin
        dt_d[i] = dt_q[i] - 1'b1;
      end else if (req[i] != LEG_OFF) begin
        state_d[i] = req[i];
      end
    end
  end

  always_comb begin
    AP = (state_q[0] == LEG_HIGH);
    AN = (state_q[0] == LEG_LOW);
    BP = (state_q[1] == LEG_HIGH);
    BN = (state_q[1] == LEG_LOW);
    CP = (state_q[2] == LEG_HIGH);
    CN = (state_q[2] == LEG_LOW);
  end

  assign pwm_out    = pwm_q;
  assign hall_state = hall_q;
  assign hall_valid = valid_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed bench for bldc_commutator with PWM_W=8, DEAD=4, FILT=3; switch outputs
// are sampled on the falling clock edge.
module tb_bldc_commutator;

  logic       clk = 1'b0;
  logic       rst, pwm_en, dir, H1, H2, H3, clear_fault;
  logic [7:0] pwm_in;
  logic       pwm_out, AP, AN, BP, BN, CP, CN, hall_valid, fault;
  logic [2:0] hall_state;

  int n_vec = 0;
  int n_err = 0;

  bldc_commutator #(.PWM_W(8), .DEAD(4), .FILT(3)) dut (
    .clk(clk), .rst(rst), .pwm_en(pwm_en), .pwm_in(pwm_in), .dir(dir),
    .H1(H1), .H2(H2), .H3(H3), .clear_fault(clear_fault), .pwm_out(pwm_out),
    .AP(AP), .AN(AN), .BP(BP), .BN(BN), .CP(CP), .CN(CN),
    .hall_state(hall_state), .hall_valid(hall_valid), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] legs();
    return {AP, AN, BP, BN, CP, CN};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Continuous leg monitor: shoot-through and short dead-time are tallied here.
  int   ov_err = 0, dt_err = 0, ap_rises = 0;
  int   off_run [3] = '{100, 100, 100};
  logic [2:0] prev_p = '0, prev_n = '0;

  always @(negedge clk) begin
    logic [5:0] l;
    l = legs();
    for (int i = 0; i < 3; i++) begin
      logic p, n;
      p = l[5 - 2*i];
      n = l[4 - 2*i];
      if (p && n) ov_err++;
      if ((p && prev_n[i]) || (n && prev_p[i])) dt_err++;
      if (p || n) begin
        if (off_run[i] != 0 && off_run[i] < 4) dt_err++;
        off_run[i] = 0;
      end else begin
        off_run[i]++;
      end
      if (i == 0 && p && !prev_p[0]) ap_rises++;
      prev_p[i] = p;
      prev_n[i] = n;
    end
  end

  logic [2:0] seq_h   [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  logic [5:0] fwd_see [6] = '{6'h24, 6'h21, 6'h09, 6'h18, 6'h12, 6'h06};
  logic [5:0] fwd_lo  [6] = '{6'h04, 6'h01, 6'h01, 6'h10, 6'h10, 6'h04};
  logic [5:0] rev_see [6] = '{6'h18, 6'h12, 6'h06, 6'h24, 6'h21, 6'h09};
  logic [5:0] rev_lo  [6] = '{6'h10, 6'h10, 6'h04, 6'h04, 6'h01, 6'h01};

  task automatic step_hall(input string tag, input logic [2:0] h,
                           input logic [5:0] exp_seen, input logic [5:0] lo_mask);
    logic [5:0] seen;
    logic       lo_ok;
    {H1, H2, H3} = h;
    seen  = '0;
    lo_ok = 1'b1;
    cyc(20);
    for (int i = 0; i < 980; i++) begin
      cyc(1);
      seen |= legs();
      if ((legs() & lo_mask) == 6'h00) lo_ok = 1'b0;
    end
    check({tag, "_seen"}, 32'(seen), 32'(exp_seen));
    check({tag, "_lo"}, 32'(lo_ok), 32'd1);
  endtask

  initial begin
    int   np, na, nb, nc, nl;
    logic ok, found;

    rst = 1'b1; pwm_en = 1'b1; pwm_in = 8'h7C; dir = 1'b0;
    {H1, H2, H3} = 3'b000; clear_fault = 1'b0;
    cyc(3);
    check("rst_legs",  32'(legs()), 32'h0);
    check("rst_valid", 32'(hall_valid), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_hall",  32'(hall_state), 32'h0);
    check("rst_pwm",   32'(pwm_out), 32'h0);

    rst = 1'b0;
    {H1, H2, H3} = 3'b101;
    cyc(4);
    check("acc_pre",   32'(hall_state), 32'h0);
    cyc(1);
    check("acc_at5",   32'(hall_state), 32'h5);
    check("acc_valid", 32'(hall_valid), 32'h1);
    check("acc_legs",  32'(legs()), 32'h0);
    cyc(1);
    check("bn_on",     32'(legs()), 32'h04);

    cyc(600);
    np = 0; na = 0; nb = 0; nc = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      np += int'(pwm_out); na += int'(AP); nb += int'(BN);
      nc += int'(AN | BP | CP | CN);
    end
    check("duty7c_pwm",  32'(np), 32'd124);
    check("duty7c_ap",   32'(na), 32'd124);
    check("duty7c_bn",   32'(nb), 32'd256);
    check("duty7c_rest", 32'(nc), 32'd0);

    for (int i = 0; i < 6; i++)
      step_hall($sformatf("fwd%0d", i), seq_h[i], fwd_see[i], fwd_lo[i]);
    dir = 1'b1;
    for (int i = 0; i < 6; i++)
      step_hall($sformatf("rev%0d", i), seq_h[i], rev_see[i], rev_lo[i]);

    dir = 1'b0;
    {H1, H2, H3} = 3'b101;
    cyc(30);
    {H1, H2, H3} = 3'b100;
    cyc(2);
    {H1, H2, H3} = 3'b101;
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      if (hall_state !== 3'b101 || BN !== 1'b1) ok = 1'b0;
    end
    check("glitch_hold", 32'(ok), 32'd1);

    {H1, H2, H3} = 3'b100;
    cyc(4);
    check("lat4", 32'(hall_state), 32'h5);
    cyc(1);
    check("lat5", 32'(hall_state), 32'h4);

    {H1, H2, H3} = 3'b111;
    cyc(5);
    check("ill_hall",  32'(hall_state), 32'h7);
    check("ill_fault", 32'(fault), 32'h1);
    check("ill_valid", 32'(hall_valid), 32'h0);
    cyc(1);
    check("ill_legs",  32'(legs()), 32'h0);
    {H1, H2, H3} = 3'b101;
    cyc(10);
    check("latch_hall",  32'(hall_state), 32'h5);
    check("latch_fault", 32'(fault), 32'h1);
    check("latch_valid", 32'(hall_valid), 32'h0);
    check("latch_legs",  32'(legs()), 32'h0);
    clear_fault = 1'b1;
    cyc(1);
    clear_fault = 1'b0;
    check("clr_fault", 32'(fault), 32'h0);
    check("clr_valid", 32'(hall_valid), 32'h0);
    cyc(1);
    check("rearm_valid", 32'(hall_valid), 32'h1);
    check("rearm_legs",  32'(legs()), 32'h0);
    cyc(1);
    check("resume_bn",   32'(BN), 32'h1);
    check("resume_rest", 32'({AN, BP, CP, CN}), 32'h0);

    pwm_in = 8'h00;
    cyc(600);
    np = 0; na = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      np += int'(pwm_out); na += int'(AP);
    end
    check("duty0_pwm", 32'(np), 32'd0);
    check("duty0_ap",  32'(na), 32'd0);

    pwm_in = 8'hFF;
    cyc(600);
    nl = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      nl += int'(!pwm_out);
    end
    check("dutyff_low", 32'(nl), 32'd1);

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cyc(1);
      if (!pwm_out) found = 1'b1;
    end
    check("wrap_found", 32'(found), 32'd1);
    cyc(10);
    pwm_in = 8'h40;
    np = 0;
    for (int i = 0; i < 245; i++) begin
      cyc(1);
      np += int'(pwm_out);
    end
    check("mid_old", 32'(np), 32'd245);
    cyc(1);
    check("mid_wrap", 32'(pwm_out), 32'h0);
    np = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      np += int'(pwm_out);
    end
    check("mid_new", 32'(np), 32'd64);

    pwm_en = 1'b0;
    cyc(1);
    check("en_legs", 32'(legs()), 32'h0);
    check("en_pwm",  32'(pwm_out), 32'h0);
    check("en_dt4",  32'(dut.dt_q[1]), 32'd4);
    cyc(1);
    check("en_dt3",  32'(dut.dt_q[1]), 32'd3);
    rst = 1'b1;
    cyc(1);
    check("rst2_legs",  32'(legs()), 32'h0);
    check("rst2_dt",    32'(dut.dt_q), 32'h0);
    check("rst2_hall",  32'(hall_state), 32'h0);
    check("rst2_valid", 32'(hall_valid), 32'h0);
    check("rst2_fault", 32'(fault), 32'h0);
    check("rst2_pwm",   32'(pwm_out), 32'h0);
    rst = 1'b0;
    pwm_en = 1'b1;
    cyc(2);

    check("no_overlap", 32'(ov_err), 32'd0);
    check("dead_time",  32'(dt_err), 32'd0);
    check("ap_chopped", 32'(ap_rises > 10), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bldc_commutator.md
# bldc_commutator

Parametrised six-step BLDC commutation and gate-drive block, the next generation of `pn_drive`. It takes raw hall-sensor inputs and a PWM duty word and produces the six phase-leg switch signals. Over `pn_drive` it adds:
- configurable PWM width,
- a hall synchroniser and glitch filter,
- a direction select,
- per-leg dead-time insertion,
- illegal-hall fault detection.

It sits between the speed/duty controller and the inverter gate drivers.

## Interface
- `PWM_W`, 8: duty word and PWM counter width.
- `DEAD`, 4: dead-time in clk cycles, minimum 1.
- `FILT`, 3: consecutive identical synchronised samples required to accept a hall change, minimum 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `pwm_en`  in  1  drive enable; low forces all switches off.
- `pwm_in`  in  PWM_W  duty word.
- `dir`  in  1  0 = forward, 1 = reverse.
- `H1`, `H2`, `H3`  in  1 each  asynchronous hall inputs.
- `clear_fault`  in  1  single-cycle pulse that clears the latched fault.
- `pwm_out`  out  1  raw PWM.
- `AP`, `AN`, `BP`, `BN`, `CP`, `CN`  out  1 each  high/low switch enables per phase.
- `hall_state`  out  3  filtered `{H1,H2,H3}`.
- `hall_valid`  out  1  a legal hall value has been accepted since reset or fault clear.
- `fault`  out  1  latched illegal-hall fault.

## Operation
- **PWM:** free-running counter `cnt`, PWM_W bits, wraps to 0.
  - `duty_q` loads `pwm_in` on the cycle `cnt` is all-ones, so a new duty takes effect from the next period.
  - `pwm_out = pwm_en & (cnt < duty_q)` (registered).
  - Duty 0 gives a constant low; all-ones duty gives low for 1 cycle per period.
- **Hall filter:**
  - Two-flop synchroniser produces `hs`.
  - A candidate register and counter track `hs`. When `hs` differs from `hall_state` and has held one value for FILT consecutive cycles, that value is loaded into `hall_state`.
  - Any change of `hs` restarts the count.
- **Hall validity:** an accepted 000 or 111 sets `fault` and clears `hall_valid`. An accepted legal value sets `hall_valid` unless `fault` is set.
- **Commutation table (forward; `{H1,H2,H3}` → high leg/low leg):** 101 A/B, 100 A/C, 110 B/C, 010 B/A, 011 C/A, 001 C/B.
  - Reverse swaps high and low, e.g. 101 → B high/A low.
  - The third leg is OFF.
- **Requested leg state:**
  - HIGH when the leg is the table's high leg and `pwm_out`=1.
  - LOW when it is the table's low leg.
  - Otherwise OFF.
  - All legs are requested OFF when `pwm_en`=0, `fault`=1 or `hall_valid`=0.
- **Per-leg dead-time FSM:**
  - States: OFF, HIGH, LOW, plus a down-counter `dt`.
  - HIGH or LOW, with request ≠ current: go to OFF and load `dt`=DEAD.
  - OFF with `dt`≠0: decrement `dt`.
  - OFF with `dt`=0 and request ≠ OFF: go to the requested state.
  - Outputs: xP=(state==HIGH), xN=(state==LOW). xP and xN are never both 1.
- **Fault:**
  - `clear_fault` clears `fault` and `hall_valid`.
  - The next accepted legal hall value, or the current legal value if `hall_state` is legal, re-arms `hall_valid` on the following cycle.
  - If `clear_fault` coincides with an illegal acceptance, `fault` stays set.

## Timing
- **Reset values:**
  - `cnt`=0, `duty_q`=0, `pwm_out`=0.
  - All leg FSMs OFF with `dt`=0.
  - All six switch outputs 0.
  - `hall_state`=000, `hall_valid`=0, `fault`=0.
  - Synchroniser and filter are cleared.
- **Hall pin change → `hall_state` update:** 2 + FILT cycles when stable.
- **`hall_state` update → request change:** combinational.
- **Leg turn-off:** 1 cycle after request change.
- **Leg turn-on from OFF:** DEAD+1 cycles after the previous turn-off edge, or 1 cycle if `dt` is already 0.
- PWM chopping of the high leg also passes through dead-time on every re-assert.
- **`pwm_en` low:** all switches 0 within 1 cycle. `pwm_out` goes 0 on the next cycle.
- **Reset mid-operation:** all outputs go to reset values on the next clk edge, regardless of `dt`.

## Test plan
Parameters: PWM_W=8, DEAD=4, FILT=3.
- **Reset:** `rst` high 3 cycles with `pwm_en`=1, `pwm_in`=0x7C → all outputs 0, `hall_valid`=0. Then halls 101, `dir`=0 → AP chops at 124/256 duty, BN steady high, C leg off, AP rises ≥4 cycles after each fall.
- **Forward/reverse stepping:** step halls 101→100→110→010→011→001, 10000 ns each → the table pairs in order. Repeat with `dir`=1 → swapped pairs. In both cases no cycle has xP & xN, and every turn-on is preceded by ≥4 all-off cycles on that leg.
- **Glitch rejection:** 2-cycle hall glitch 101→100→101 → `hall_state` stays 101 and outputs are unchanged. A 3-cycle-stable change is accepted at exactly 5 cycles after the pin edge.
- **Illegal hall:** halls 111 stable → `fault`=1 and all switches 0 within one cycle of acceptance. Halls back to 101 → still faulted. `clear_fault` pulse → `hall_valid` rises and drive resumes after dead-time.
- **Duty boundaries:** `pwm_in`=0 → AP never asserts. `pwm_in`=0xFF → `pwm_out` low exactly 1 of 256 cycles. A duty change mid-period takes effect only after `cnt` wraps.
- **Enable and reset mid-operation:** drop `pwm_en` mid-step → all switches 0 next cycle. Assert `rst` during a dead-time countdown → outputs 0 and the FSM is OFF with `dt`=0.
